// File: rtl/fifo_prog.sv
// Single-clock FWFT FIFO with occupancy count, programmable almost flags, flush and sticky errors.
// Head data is visible the cycle after the write; a push while full is dropped unless a pull happens in the same cycle.
module fifo_prog #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 15,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           datain,
  input  logic                       pull,
  output logic [WIDTH-1:0]           dataout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty,
  input  logic                       flush,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;
  logic             push_rej;
  logic             pull_rej;

  // A pull on a full FIFO frees the slot the simultaneous push lands in.
  assign wr_en    = push && (!full || pull);
  assign rd_en    = pull && !empty;
  assign push_rej = push && full && !pull;
  assign pull_rej = pull && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error in the same cycle as err_clr keeps the flag set.
      if (push_rej)     overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (pull_rej)     underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) mem[wr_ptr] <= datain;
  end

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign dataout      = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog with a queue-based reference model and scoreboard.
module tb_fifo_prog;
  localparam int WIDTH = 32;
  localparam int DEPTH = 15;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst, push, pull, flush, err_clr;
  logic [WIDTH-1:0] datain, dataout;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]       count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb[$];
  logic             ovf_m, unf_m;

  fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .push(push), .datain(datain), .pull(pull),
    .dataout(dataout), .full(full), .empty(empty), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty), .flush(flush),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int n;
    n = sb.size();
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("almost_full", 64'(almost_full), 64'(n >= AF));
    chk("almost_empty", 64'(almost_empty), 64'(n <= AE));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    chk("underflow", 64'(underflow), 64'(unf_m));
    chk("dataout", 64'(dataout), (n > 0) ? 64'(sb[0]) : 64'd0);
  endtask

  // One clock with the given inputs; the model follows the FIFO contract, not the RTL structure.
  task automatic cyc(input logic p, input logic [WIDTH-1:0] d, input logic l,
                     input logic f, input logic e);
    logic wr, rd;
    push = p; datain = d; pull = l; flush = f; err_clr = e;
    if (!f && l && sb.size() > 0) chk("scoreboard_head", 64'(dataout), 64'(sb[0]));
    wr = p && ((sb.size() < DEPTH) || l);
    rd = l && (sb.size() > 0);
    @(posedge clk);
    #1;
    if (f) begin
      sb.delete();
    end else begin
      if (p && sb.size() == DEPTH && !l) ovf_m = 1'b1;
      else if (e) ovf_m = 1'b0;
      if (l && sb.size() == 0) unf_m = 1'b1;
      else if (e) unf_m = 1'b0;
      if (rd) void'(sb.pop_front());
      if (wr) sb.push_back(d);
    end
    push = 1'b0; pull = 1'b0; flush = 1'b0; err_clr = 1'b0;
    chk_state();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    chk_state();
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pull = 1'b0; flush = 1'b0; err_clr = 1'b0; datain = '0;
    ovf_m = 1'b0; unf_m = 1'b0;
    @(posedge clk);
    do_reset();

    // Fill to full, then drain in order.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    chk("filled_count", 64'(count), 64'd15);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drained_empty", 64'(empty), 64'd1);

    // FWFT latency.
    cyc(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    chk("fwft_data", 64'(dataout), 64'hA5A5A5A5);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fwft_empty_data", 64'(dataout), 64'd0);

    // Full boundary: dropped push, then simultaneous push+pull.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h1000 + i, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("overflow_set", 64'(overflow), 64'd1);
    cyc(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0);
    chk("full_pp_count", 64'(count), 64'd15);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("overflow_cleared", 64'(overflow), 64'd0);

    // Empty boundary.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("underflow_set", 64'(underflow), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h3333, 1'b1, 1'b0, 1'b0);
    chk("empty_pp_count", 64'(count), 64'd1);
    chk("empty_pp_underflow", 64'(underflow), 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("clr_vs_set_underflow", 64'(underflow), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Wrap-around with occupancy held between 5 and 9.
    for (int i = 0; i < 7; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic p, l;
      p = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      if (sb.size() <= 5) l = 1'b0;
      if (sb.size() >= 9) p = 1'b0;
      cyc(p, $urandom, l, 1'b0, 1'b0);
    end
    while (sb.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush mid-operation with push and pull asserted.
    for (int i = 0; i < 8; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h5555, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_no_err", 64'({overflow, underflow}), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h7000 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset with data inside.
    for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("reset_dataout", 64'(dataout), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
